// File: rtl/ft232h_emu_pkg.sv
// Shared types for the FT232H 245-sync-FIFO device emulator.
// No logic; holds the TX pacing state type and the err_o bit positions.
package ft232h_emu_pkg;

  typedef enum logic {
    TX_OPEN = 1'b0,
    TX_GAP  = 1'b1
  } tx_state_t;

  localparam int ERR_WR_DROP    = 0;
  localparam int ERR_RD_EMPTY   = 1;
  localparam int ERR_CONTENTION = 2;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: pop_data always shows the head, count is registered.
// Push/pop take effect on the same edge; callers gate push when full and pop when empty.
module sync_fifo_fwft #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ft232h_fifo_emulator.sv
// Device-side FT232H 245 sync FIFO model: RX FIFO feeds the bus, TX FIFO captures it; flags one cycle after the edge.
// RXF#/TXE# are registered from next-state counts so the FPGA never over/under-runs; host side is valid/ready.
module ft232h_fifo_emulator #(
  parameter int DEPTH  = 512,
  parameter int TX_PKT = 512,
  parameter int TX_GAP = 16
) (
  input  logic                       usb_clk_i,
  input  logic                       rst,
  inout  wire  [7:0]                 usb_data_io,
  output logic                       usb_rxf_n_o,
  output logic                       usb_txe_n_o,
  input  logic                       usb_rd_n_i,
  input  logic                       usb_wr_n_i,
  input  logic                       usb_oe_n_i,
  input  logic                       host_wr_valid_i,
  output logic                       host_wr_ready_o,
  input  logic [7:0]                 host_wr_data_i,
  output logic                       host_rd_valid_o,
  input  logic                       host_rd_ready_i,
  output logic [7:0]                 host_rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] rx_level_o,
  output logic [$clog2(DEPTH+1)-1:0] tx_level_o,
  output logic [2:0]                 err_o
);

  import ft232h_emu_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (TX_PKT > 1) ? $clog2(TX_PKT) : 1;
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  logic          oe_q;
  logic [7:0]    rx_head;
  logic          wr_req, rd_req;
  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic [CW-1:0] rx_count, tx_count, rx_count_next, tx_count_next;
  tx_state_t     state, state_next;
  logic [PW-1:0] pkt_cnt, pkt_cnt_next;
  logic [GW-1:0] gap_cnt, gap_cnt_next;

  assign wr_req  = ~usb_wr_n_i;
  assign rd_req  = ~usb_rd_n_i & ~usb_oe_n_i;
  assign rx_push = host_wr_valid_i & host_wr_ready_o;
  assign rx_pop  = rd_req & ~usb_rxf_n_o;
  // A write with OE# low is bus contention and is never captured.
  assign tx_push = wr_req & ~usb_txe_n_o & usb_oe_n_i;
  assign tx_pop  = host_rd_valid_o & host_rd_ready_i;

  assign host_wr_ready_o = ~rst & (rx_count < CW'(DEPTH));
  assign host_rd_valid_o = (tx_count != '0);
  assign rx_level_o      = rx_count;
  assign tx_level_o      = tx_count;
  assign rx_count_next   = rx_count + CW'(rx_push) - CW'(rx_pop);
  assign tx_count_next   = tx_count + CW'(tx_push) - CW'(tx_pop);

  assign usb_data_io = oe_q ? rx_head : 8'bz;

  sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk       (usb_clk_i),
    .rst       (rst),
    .push      (rx_push),
    .push_data (host_wr_data_i),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .count     (rx_count)
  );

  sync_fifo_fwft #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk       (usb_clk_i),
    .rst       (rst),
    .push      (tx_push),
    .push_data (usb_data_io),
    .pop       (tx_pop),
    .pop_data  (host_rd_data_o),
    .count     (tx_count)
  );

  always_comb begin
    state_next   = state;
    pkt_cnt_next = pkt_cnt;
    gap_cnt_next = gap_cnt;
    case (state)
      ft232h_emu_pkg::TX_OPEN: begin
        if (tx_push) begin
          if (pkt_cnt == PW'(TX_PKT - 1)) begin
            pkt_cnt_next = '0;
            if (TX_GAP != 0) begin
              state_next   = ft232h_emu_pkg::TX_GAP;
              gap_cnt_next = GW'(TX_GAP - 1);
            end
          end else begin
            pkt_cnt_next = pkt_cnt + 1'b1;
          end
        end
      end
      ft232h_emu_pkg::TX_GAP: begin
        if (gap_cnt == '0) state_next = ft232h_emu_pkg::TX_OPEN;
        else               gap_cnt_next = gap_cnt - 1'b1;
      end
      default: state_next = ft232h_emu_pkg::TX_OPEN;
    endcase
  end

  always_ff @(posedge usb_clk_i) begin
    if (rst) begin
      state       <= ft232h_emu_pkg::TX_OPEN;
      pkt_cnt     <= '0;
      gap_cnt     <= '0;
      oe_q        <= 1'b0;
      usb_rxf_n_o <= 1'b1;
      usb_txe_n_o <= 1'b1;
      err_o       <= '0;
    end else begin
      state       <= state_next;
      pkt_cnt     <= pkt_cnt_next;
      gap_cnt     <= gap_cnt_next;
      oe_q        <= ~usb_oe_n_i;
      usb_rxf_n_o <= (rx_count_next == '0);
      usb_txe_n_o <= (tx_count_next == CW'(DEPTH)) | (state_next == ft232h_emu_pkg::TX_GAP);
      err_o[ERR_WR_DROP]    <= err_o[ERR_WR_DROP] | (wr_req & usb_txe_n_o);
      err_o[ERR_RD_EMPTY]   <= err_o[ERR_RD_EMPTY] | (rd_req & usb_rxf_n_o);
      err_o[ERR_CONTENTION] <= err_o[ERR_CONTENTION] | (wr_req & ~usb_oe_n_i);
    end
  end

endmodule

// File: tb/tb_ft232h_fifo_emulator.sv
// Directed bench for ft232h_fifo_emulator with byte scoreboards on both directions.
module tb_ft232h_fifo_emulator;

  localparam int DEPTH  = 8;
  localparam int TX_PKT = 8;
  localparam int TX_GAP = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  wire  [7:0]    usb_data;
  logic [7:0]    fpga_dat;
  logic          fpga_drv;
  logic          rxf_n, txe_n, rd_n, wr_n, oe_n;
  logic          hw_valid, hw_ready, hr_valid, hr_ready;
  logic [7:0]    hw_data, hr_data;
  logic [CW-1:0] rx_level, tx_level;
  logic [2:0]    err;

  int         checks = 0;
  int         errors = 0;
  int         rx_popped = 0;
  int         tx_popped = 0;
  int         sent, ws, gap, base;
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  logic [7:0] exp_b;

  assign usb_data = fpga_drv ? fpga_dat : 8'bz;

  ft232h_fifo_emulator #(.DEPTH(DEPTH), .TX_PKT(TX_PKT), .TX_GAP(TX_GAP)) u_dut (
    .usb_clk_i       (clk),
    .rst             (rst),
    .usb_data_io     (usb_data),
    .usb_rxf_n_o     (rxf_n),
    .usb_txe_n_o     (txe_n),
    .usb_rd_n_i      (rd_n),
    .usb_wr_n_i      (wr_n),
    .usb_oe_n_i      (oe_n),
    .host_wr_valid_i (hw_valid),
    .host_wr_ready_o (hw_ready),
    .host_wr_data_i  (hw_data),
    .host_rd_valid_o (hr_valid),
    .host_rd_ready_i (hr_ready),
    .host_rd_data_o  (hr_data),
    .rx_level_o      (rx_level),
    .tx_level_o      (tx_level),
    .err_o           (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; record transfers the next edge will perform, then advance.
  task automatic cycle();
    if (!rst) begin
      if (hw_valid && hw_ready) rx_q.push_back(hw_data);
      if (!rd_n && !oe_n && !rxf_n) begin
        if (rx_q.size() == 0) chk("rx_unexpected_pop", 32'd1, 32'd0);
        else begin
          exp_b = rx_q.pop_front();
          chk("rx_data", {24'd0, usb_data}, {24'd0, exp_b});
        end
        rx_popped++;
      end
      if (hr_valid && hr_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected_out", 32'd1, 32'd0);
        else begin
          exp_b = tx_q.pop_front();
          chk("tx_data", {24'd0, hr_data}, {24'd0, exp_b});
        end
        tx_popped++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1;
    hw_valid = 1'b0; hw_data = 8'h00; hr_ready = 1'b0;
    fpga_drv = 1'b0; fpga_dat = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rxf_n", rxf_n, 1);
    chk("rst_txe_n", txe_n, 1);
    chk("rst_wr_ready", hw_ready, 0);
    chk("rst_rd_valid", hr_valid, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_err", err, 0);
    fpga_drv = 1'b1; fpga_dat = 8'h5A; #1;
    chk("rst_bus_z", usb_data, 8'h5A);
    fpga_drv = 1'b0;
    rst = 1'b0;
    cycle();
    chk("rel_txe_n", txe_n, 0);
    chk("rel_wr_ready", hw_ready, 1);
    chk("rel_rxf_n", rxf_n, 1);

    // RX: host pushes 0x10..0x1F, FPGA reads with OE# one cycle ahead of RD#.
    oe_n = 1'b0; hw_valid = 1'b1; hw_data = 8'h10;
    cycle();
    sent = 1;
    chk("rx_rxf_latency", rxf_n, 0);
    chk("rx_bus_head", usb_data, 8'h10);
    for (int g = 0; g < 100 && rx_popped < 16; g++) begin
      hw_valid = (sent < 16);
      hw_data  = 8'h10 + 8'(sent);
      if (hw_valid && hw_ready) sent++;
      rd_n = rxf_n;
      cycle();
    end
    chk("rx_pop_count", rx_popped, 16);
    chk("rx_rxf_after_last", rxf_n, 1);
    chk("rx_level_empty", rx_level, 0);
    chk("rx_err", err, 0);
    rd_n = 1'b1; oe_n = 1'b1; hw_valid = 1'b0;
    cycle();

    // TX: 16 bytes honouring TXE#, measure the gap after the 8th.
    hr_ready = 1'b1; ws = 0; gap = 0;
    for (int g = 0; g < 200 && tx_popped < 16; g++) begin
      if (ws == 8 && txe_n) gap++;
      if (ws < 16 && !txe_n) begin
        wr_n = 1'b0; fpga_drv = 1'b1; fpga_dat = 8'(ws);
        tx_q.push_back(8'(ws));
        ws++;
      end else begin
        wr_n = 1'b1; fpga_drv = 1'b0;
      end
      cycle();
    end
    wr_n = 1'b1; fpga_drv = 1'b0;
    chk("tx_pop_count", tx_popped, 16);
    chk("tx_gap_len", gap, TX_GAP);
    chk("tx_level_empty", tx_level, 0);
    chk("tx_err", err, 0);

    // Overflow: host stalled, FPGA writes 10 bytes ignoring TXE#.
    hr_ready = 1'b0;
    for (int g = 0; g < 20 && txe_n; g++) cycle();
    chk("ovf_open_wait", txe_n, 0);
    for (int i = 0; i < 10; i++) begin
      wr_n = 1'b0; fpga_drv = 1'b1; fpga_dat = 8'hA0 + 8'(i);
      if (i < DEPTH) tx_q.push_back(fpga_dat);
      cycle();
    end
    wr_n = 1'b1; fpga_drv = 1'b0;
    cycle();
    chk("ovf_tx_level", tx_level, DEPTH);
    chk("ovf_txe_n", txe_n, 1);
    chk("ovf_err", err, 3'b001);
    hr_ready = 1'b1;
    for (int g = 0; g < 40 && tx_popped < 16 + DEPTH; g++) cycle();
    chk("ovf_drained", tx_popped, 16 + DEPTH);
    hr_ready = 1'b0;

    // Read from empty RX, then OE#+WR# contention.
    for (int g = 0; g < 20 && txe_n; g++) cycle();
    chk("err_open_wait", txe_n, 0);
    oe_n = 1'b0; rd_n = 1'b0;
    cycle();
    rd_n = 1'b1; oe_n = 1'b1;
    cycle();
    chk("rd_empty_err", err, 3'b011);
    chk("rd_empty_level", rx_level, 0);
    oe_n = 1'b0; wr_n = 1'b0;
    cycle();
    wr_n = 1'b1; oe_n = 1'b1;
    cycle();
    chk("cont_err", err, 3'b111);
    chk("cont_no_capture", tx_level, 0);
    chk("cont_no_valid", hr_valid, 0);

    // Streaming: prefill 4, then push and pop together for 64 bytes.
    oe_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hw_valid = 1'b1; hw_data = 8'h40 + 8'(i);
      cycle();
    end
    chk("stream_prefill", rx_level, 4);
    base = rx_popped;
    for (int i = 0; i < 64; i++) begin
      hw_valid = 1'b1; hw_data = 8'h44 + 8'(i); rd_n = 1'b0;
      cycle();
      chk("stream_level", rx_level, 4);
    end
    hw_valid = 1'b0;
    for (int g = 0; g < 10 && rx_popped < base + 68; g++) begin
      rd_n = rxf_n;
      cycle();
    end
    chk("stream_drained", rx_popped - base, 68);
    chk("stream_sb_empty", rx_q.size(), 0);
    rd_n = 1'b1; oe_n = 1'b1;
    cycle();

    // Reset mid-transfer with 3 bytes in each FIFO.
    hr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hw_valid = 1'b1; hw_data = 8'h50 + 8'(i);
      wr_n = 1'b0; fpga_drv = 1'b1; fpga_dat = 8'h60 + 8'(i);
      cycle();
    end
    hw_valid = 1'b0; wr_n = 1'b1; fpga_drv = 1'b0; oe_n = 1'b0;
    cycle();
    chk("mid_rx_level", rx_level, 3);
    chk("mid_tx_level", tx_level, 3);
    chk("mid_bus_head", usb_data, 8'h50);
    rst = 1'b1;
    cycle();
    chk("mid_rst_rx_level", rx_level, 0);
    chk("mid_rst_tx_level", tx_level, 0);
    chk("mid_rst_rxf_n", rxf_n, 1);
    chk("mid_rst_txe_n", txe_n, 1);
    chk("mid_rst_rd_valid", hr_valid, 0);
    fpga_drv = 1'b1; fpga_dat = 8'hC3; #1;
    chk("mid_rst_bus_z", usb_data, 8'hC3);
    fpga_drv = 1'b0;
    rx_q.delete();
    tx_q.delete();
    rst = 1'b0; oe_n = 1'b1;
    cycle();
    chk("post_txe_n", txe_n, 0);
    chk("post_wr_ready", hw_ready, 1);
    chk("post_rxf_n", rxf_n, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
